// File: rtl/gpu_linker_pkg.sv
// Shared types and sizing for the GPU linker: opcodes, controller states,
// lane geometry and the store byte-enable helper.
package gpu_linker_pkg;

  localparam int NUM_LANES = 24;
  localparam int NUM_REGS  = 8;
  localparam int LANE_W    = 5;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_MUL   = 4'b0010,
    OP_LOAD  = 4'b1010,
    OP_STORE = 4'b1110
  } opcodeT;

  typedef enum logic [1:0] {
    IDLE,
    ALU,
    MEM_REQ,
    MEM_NEXT
  } stateT;

  // One half-word-pair enable per 32-bit slot of the 128-bit line.
  function automatic logic [7:0] storeMask(input logic [1:0] wordSel);
    return 8'h03 << {wordSel, 1'b0};
  endfunction

endpackage

// File: rtl/gpu_lane.sv
// One SIMD lane: eight 32-bit registers, ADD/MUL datapath and per-lane
// memory word address / store data / load capture.
module gpu_lane
  import gpu_linker_pkg::*;
#(
  parameter int LANE_ID = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         aluWe,
  input  logic         loadWe,
  input  logic         isMul,
  input  logic [2:0]   rd,
  input  logic [2:0]   rs,
  input  logic [2:0]   rt,
  input  logic         immFlag,
  input  logic [31:0]  aluImm,
  input  logic [27:0]  memImm,
  input  logic [127:0] readData,
  output logic [27:0]  memWord,
  output logic [31:0]  storeData
);

  logic [31:0] regs [NUM_REGS];
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] aluResult;
  logic [31:0] loadWord;

  always_comb begin
    opA       = regs[rs];
    opB       = immFlag ? aluImm : regs[rt];
    aluResult = isMul ? opA * opB : opA + opB;
  end

  // Only bits [27:0] of the word address ever reach the memory port.
  assign memWord   = regs[rs][27:0] + memImm;
  assign storeData = regs[rd];
  assign loadWord  = readData[{memWord[1:0], 5'b00000} +: 32];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= (r == 0) ? 32'(LANE_ID) : 32'd0;
      end
    end else if (aluWe) begin
      regs[rd] <= aluResult;
    end else if (loadWe) begin
      regs[rd] <= loadWord;
    end
  end

endmodule

// File: rtl/gpu_linker.sv
// Linker top: issue control FSM, 24 lanes, and the serialized per-lane
// memory request mux with registered memory-side outputs.
module gpu_linker
  import gpu_linker_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  instruction,
  input  logic         executeInstruction,
  output logic         coresReady,
  input  logic         globalMemFinishedAction,
  output logic [25:0]  globalMemAddr,
  output logic [127:0] globalMemDataWrite,
  output logic [7:0]   writeBytes,
  input  logic [127:0] globalMemReadData,
  output logic         globalEnable,
  output logic         globalWriteEnable
);

  stateT stateReg, stateNext;
  logic [LANE_W-1:0] laneReg, laneNext;
  logic [31:0] instrReg;
  logic [31:0] curInstr;
  logic        accept;
  logic        isAdd, isMul, isLoad, isStore;
  logic        memActive;
  logic        loadStrobe;
  logic [31:0] aluImm;
  logic [27:0] memImm;
  logic [27:0] laneWord  [NUM_LANES];
  logic [31:0] laneStore [NUM_LANES];
  logic [27:0] selWord;
  logic [31:0] selStore;

  // The live input is decoded at acceptance; the latched copy drives memory ops.
  assign curInstr = (stateReg == IDLE) ? instruction : instrReg;
  assign isAdd    = curInstr[31:28] == OP_ADD;
  assign isMul    = curInstr[31:28] == OP_MUL;
  assign isLoad   = curInstr[31:28] == OP_LOAD;
  assign isStore  = curInstr[31:28] == OP_STORE;
  assign aluImm   = {{11{curInstr[20]}}, curInstr[20:0]};
  assign memImm   = {{6{curInstr[21]}}, curInstr[21:0]};
  assign accept   = (stateReg == IDLE) && executeInstruction && coresReady;
  assign loadStrobe = (stateReg == MEM_REQ) && globalMemFinishedAction && isLoad;

  always_comb begin
    stateNext = stateReg;
    laneNext  = laneReg;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          if (isLoad || isStore) begin
            stateNext = MEM_REQ;
            laneNext  = '0;
          end else begin
            stateNext = ALU;
          end
        end
      end
      ALU: stateNext = IDLE;
      MEM_REQ: begin
        if (globalMemFinishedAction) stateNext = MEM_NEXT;
      end
      MEM_NEXT: begin
        if (laneReg == LANE_W'(NUM_LANES - 1)) begin
          stateNext = IDLE;
          laneNext  = '0;
        end else begin
          stateNext = MEM_REQ;
          laneNext  = laneReg + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : gLane
    gpu_lane #(.LANE_ID(gi)) uLane (
      .clk       (clk),
      .reset     (reset),
      .aluWe     (accept && (isAdd || isMul)),
      .loadWe    (loadStrobe && (laneReg == LANE_W'(gi))),
      .isMul     (isMul),
      .rd        (curInstr[27:25]),
      .rs        (curInstr[24:22]),
      .rt        (curInstr[2:0]),
      .immFlag   (curInstr[21]),
      .aluImm    (aluImm),
      .memImm    (memImm),
      .readData  (globalMemReadData),
      .memWord   (laneWord[gi]),
      .storeData (laneStore[gi])
    );
  end

  // Outputs are computed for the lane that will be requesting next cycle.
  assign memActive = (stateNext == MEM_REQ);
  assign selWord   = laneWord[laneNext];
  assign selStore  = laneStore[laneNext];

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg           <= IDLE;
      laneReg            <= '0;
      instrReg           <= '0;
      coresReady         <= 1'b0;
      globalEnable       <= 1'b0;
      globalWriteEnable  <= 1'b0;
      writeBytes         <= '0;
      globalMemAddr      <= '0;
      globalMemDataWrite <= '0;
    end else begin
      stateReg          <= stateNext;
      laneReg           <= laneNext;
      coresReady        <= (stateNext == IDLE);
      globalEnable      <= memActive;
      globalWriteEnable <= memActive && isStore;
      if (accept) instrReg <= instruction;
      if (memActive) begin
        globalMemAddr      <= selWord[27:2];
        globalMemDataWrite <= {4{selStore}};
        writeBytes         <= isStore ? storeMask(selWord[1:0]) : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_gpu_linker.sv
// Randomized self-checking bench for gpu_linker; register contents are
// observed through STORE dumps against a per-lane array model.
module tb_gpu_linker;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  instruction = '0;
  logic         executeInstruction = 1'b0;
  logic         coresReady;
  logic         globalMemFinishedAction = 1'b0;
  logic [25:0]  globalMemAddr;
  logic [127:0] globalMemDataWrite;
  logic [7:0]   writeBytes;
  logic [127:0] globalMemReadData = '0;
  logic         globalEnable;
  logic         globalWriteEnable;

  int checks = 0;
  int fails  = 0;
  logic [31:0] mr [24][8];

  gpu_linker dut (
    .clk                     (clk),
    .reset                   (reset),
    .instruction             (instruction),
    .executeInstruction      (executeInstruction),
    .coresReady              (coresReady),
    .globalMemFinishedAction (globalMemFinishedAction),
    .globalMemAddr           (globalMemAddr),
    .globalMemDataWrite      (globalMemDataWrite),
    .writeBytes              (writeBytes),
    .globalMemReadData       (globalMemReadData),
    .globalEnable            (globalEnable),
    .globalWriteEnable       (globalWriteEnable)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] encAlu(input logic [3:0] op, input logic [2:0] rd,
      input logic [2:0] rs, input logic fl, input logic [20:0] imm, input logic [2:0] rt);
    logic [31:0] w;
    w = {op, rd, rs, fl, imm};
    if (!fl) w[2:0] = rt;
    return w;
  endfunction

  function automatic logic [31:0] encMem(input logic [3:0] op, input logic [2:0] rd,
      input logic [2:0] rs, input logic [21:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 24; i++)
      for (int r = 0; r < 8; r++) mr[i][r] = (r == 0) ? i : 0;
  endtask

  task automatic issue(input logic [31:0] ins);
    int t = 0;
    while (coresReady !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (coresReady !== 1'b1) begin
      fails++; $display("FAIL issue_ready got=%b want=1", coresReady);
    end
    instruction = ins;
    executeInstruction = 1'b1;
    @(negedge clk);
    executeInstruction = 1'b0;
  endtask

  task automatic exec_alu(input logic [31:0] ins);
    logic [3:0] op;
    logic [31:0] a, b;
    logic [31:0] si;
    op = ins[31:28];
    si = {{11{ins[20]}}, ins[20:0]};
    issue(ins);
    checks++;
    if (coresReady !== 1'b0 || globalEnable !== 1'b0) begin
      fails++; $display("FAIL alu_busy ins=%h ready=%b en=%b want 0/0", ins, coresReady, globalEnable);
    end
    if (op == 4'b0000 || op == 4'b0010) begin
      for (int i = 0; i < 24; i++) begin
        a = mr[i][ins[24:22]];
        b = ins[21] ? si : mr[i][ins[2:0]];
        mr[i][ins[27:25]] = (op == 4'b0000) ? a + b : a * b;
      end
    end
    @(negedge clk);
    checks++;
    if (coresReady !== 1'b1 || globalEnable !== 1'b0) begin
      fails++; $display("FAIL alu_done ins=%h ready=%b en=%b want 1/0", ins, coresReady, globalEnable);
    end
    $display("ALU ins=%h done", ins);
  endtask

  task automatic exec_mem(input logic [31:0] ins, input bit spam, input bit fixedData);
    logic [2:0] rd, rs;
    logic [31:0] mi, w;
    logic [127:0] rdat;
    bit st;
    int t, d;
    rd = ins[27:25]; rs = ins[24:22];
    mi = {{10{ins[21]}}, ins[21:0]};
    st = (ins[31:28] == 4'b1110);
    issue(ins);
    for (int i = 0; i < 24; i++) begin
      w = mr[i][rs] + mi;
      if (spam) begin
        instruction = encAlu(4'b0000, 3'd1, 3'd0, 1'b1, 21'd5, 3'd0);
        executeInstruction = 1'b1;
      end
      t = 0;
      while (globalEnable !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      checks++;
      if (globalEnable !== 1'b1 || globalMemAddr !== w[27:2] || globalWriteEnable !== st) begin
        fails++; $display("FAIL mem_req lane=%0d en=%b addr=%h we=%b want 1 %h %b",
                          i, globalEnable, globalMemAddr, w[27:2], globalWriteEnable, st);
      end
      if (st) begin
        checks++;
        if (writeBytes !== (8'h03 << (2 * w[1:0])) || globalMemDataWrite !== {4{mr[i][rd]}}) begin
          fails++; $display("FAIL store_data lane=%0d wb=%h data=%h want %h %h", i, writeBytes,
                            globalMemDataWrite, 8'h03 << (2 * w[1:0]), {4{mr[i][rd]}});
        end
      end
      d = $urandom_range(1, 5);
      repeat (d - 1) @(negedge clk);
      checks++;
      if (globalEnable !== 1'b1 || globalMemAddr !== w[27:2] || globalWriteEnable !== st) begin
        fails++; $display("FAIL mem_stable lane=%0d en=%b addr=%h we=%b", i, globalEnable,
                          globalMemAddr, globalWriteEnable);
      end
      rdat = fixedData ? {32'h3, 32'h2, 32'h1, 32'h0} : {$urandom, $urandom, $urandom, $urandom};
      globalMemReadData = rdat;
      globalMemFinishedAction = 1'b1;
      executeInstruction = 1'b0;
      if (!st) mr[i][rd] = rdat[32 * w[1:0] +: 32];
      @(negedge clk);
      globalMemFinishedAction = 1'b0;
    end
    checks++;
    if (globalEnable !== 1'b0 || coresReady !== 1'b0) begin
      fails++; $display("FAIL mem_end en=%b ready=%b want 0/0", globalEnable, coresReady);
    end
    @(negedge clk);
    checks++;
    if (coresReady !== 1'b1 || globalEnable !== 1'b0) begin
      fails++; $display("FAIL mem_ready ready=%b en=%b want 1/0", coresReady, globalEnable);
    end
    $display("MEM ins=%h store=%0d done", ins, st);
  endtask

  task automatic dump_reg(input logic [2:0] r);
    exec_mem(encMem(4'b1110, r, 3'd0, 22'($urandom)), 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (coresReady !== 1'b0 || globalEnable !== 1'b0 || globalWriteEnable !== 1'b0 ||
        writeBytes !== 8'h0 || globalMemAddr !== 26'h0 || globalMemDataWrite !== 128'h0) begin
      fails++; $display("FAIL reset_outputs ready=%b en=%b we=%b wb=%h addr=%h want all 0",
                        coresReady, globalEnable, globalWriteEnable, writeBytes, globalMemAddr);
    end
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (coresReady !== 1'b1) begin
      fails++; $display("FAIL reset_release ready=%b want 1", coresReady);
    end
    $display("RESET done");
  endtask

  task automatic test_add();
    exec_alu(32'h05E00001);
    dump_reg(3'd2);
  endtask

  task automatic test_mul();
    exec_alu(32'h26A0FF0E);
    dump_reg(3'd3);
  endtask

  task automatic test_store();
    exec_mem(encMem(4'b1110, 3'd0, 3'd0, 22'd0), 1'b0, 1'b0);
  endtask

  task automatic test_load();
    exec_mem(encMem(4'b1010, 3'd6, 3'd0, 22'd0), 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (mr[i][6] !== 32'(i % 4)) begin
        fails++; $display("FAIL load_model lane=%0d got=%h want=%h", i, mr[i][6], i % 4);
      end
    end
    dump_reg(3'd6);
  endtask

  task automatic test_busy_ignore();
    exec_mem(encMem(4'b1010, 3'd4, 3'd0, 22'($urandom)), 1'b1, 1'b0);
    for (int r = 1; r < 8; r++) dump_reg(3'(r));
  endtask

  task automatic test_unknown();
    exec_alu(encAlu(4'b0101, 3'd1, 3'd2, 1'b1, 21'h1234, 3'd0));
    exec_alu(encAlu(4'b1111, 3'd2, 3'd1, 1'b0, 21'h0, 3'd3));
    dump_reg(3'd1);
  endtask

  task automatic test_idle_finish();
    globalMemReadData = {4{32'hDEADBEEF}};
    globalMemFinishedAction = 1'b1;
    @(negedge clk);
    globalMemFinishedAction = 1'b0;
    @(negedge clk);
    checks++;
    if (coresReady !== 1'b1 || globalEnable !== 1'b0) begin
      fails++; $display("FAIL idle_finish ready=%b en=%b want 1/0", coresReady, globalEnable);
    end
    dump_reg(3'd6);
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 20; n++) begin
      k = $urandom_range(0, 4);
      case (k)
        0: exec_alu(encAlu(4'b0000, 3'($urandom), 3'($urandom), 1'($urandom), 21'($urandom), 3'($urandom)));
        1: exec_alu(encAlu(4'b0010, 3'($urandom), 3'($urandom), 1'($urandom), 21'($urandom), 3'($urandom)));
        2: exec_mem(encMem(4'b1010, 3'($urandom), 3'($urandom), 22'($urandom)), 1'b0, 1'b0);
        3: exec_mem(encMem(4'b1110, 3'($urandom), 3'($urandom), 22'($urandom)), 1'b0, 1'b0);
        default: exec_alu(encAlu(4'b0111, 3'($urandom), 3'($urandom), 1'b1, 21'($urandom), 3'd0));
      endcase
    end
    for (int r = 0; r < 8; r++) dump_reg(3'(r));
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      exec_alu(encAlu(4'b0000, 3'd5, 3'd5, 1'b1, 21'h1FFFFF, 3'd0));
    dump_reg(3'd5);
  endtask

  task automatic test_reset_mid_load();
    int t = 0;
    issue(encMem(4'b1010, 3'd0, 3'd0, 22'd0));
    while (globalEnable !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    reset = 1'b0;
    globalMemFinishedAction = 1'b1;
    @(negedge clk);
    globalMemFinishedAction = 1'b0;
    checks++;
    if (globalEnable !== 1'b0 || coresReady !== 1'b0) begin
      fails++; $display("FAIL midreset_en en=%b ready=%b want 0/0", globalEnable, coresReady);
    end
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (coresReady !== 1'b1 || globalEnable !== 1'b0) begin
      fails++; $display("FAIL midreset_release ready=%b en=%b want 1/0", coresReady, globalEnable);
    end
    dump_reg(3'd0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_store();
    test_load();
    test_busy_ignore();
    test_unknown();
    test_idle_finish();
    test_back_to_back();
    test_random();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
